// File: rtl/multicycle_add_sub.sv
// Sequential WIDTH-bit add/sub, CHUNK bits per cycle, valid/ready on both sides.
// Optional macro SATURATE_EN clamps the sum to the signed extreme on overflow.
module multicycle_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic              last;
    logic [CHUNK-1:0]  a_lo, b_lo;
    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic [WIDTH-1:0]  res_next, final_sum;
    logic              c_msb, ovf_now;
    logic              out_valid_q, c_out_q, ovf_q, zero_q;
    logic [WIDTH-1:0]  sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == IDLE);
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operands shift right one chunk per cycle; the result fills in from the top.
    always_comb begin
        last      = (cnt_q == CW'(NCHUNK - 1));
        a_lo      = a_q[CHUNK-1:0];
        b_lo      = b_q[CHUNK-1:0];
        chunk_sum = {1'b0, a_lo} + {1'b0, b_lo} + {{CHUNK{1'b0}}, carry_q};
        res_cat   = {chunk_sum[CHUNK-1:0], res_q};
        res_next  = res_cat[WIDTH+CHUNK-1:CHUNK];
        // Carry into the MSB recovered from the top sum bit of the final chunk.
        c_msb     = a_lo[CHUNK-1] ^ b_lo[CHUNK-1] ^ chunk_sum[CHUNK-1];
        ovf_now   = c_msb ^ chunk_sum[CHUNK];
`ifdef SATURATE_EN
        if (ovf_now)
            final_sum = a_lo[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        else
            final_sum = res_next;
`else
        final_sum = res_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= x;
                    b_q     <= y ^ {WIDTH{sel}};
                    carry_q <= sel;
                    cnt_q   <= '0;
                    res_q   <= '0;
                end
                BUSY: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    res_q   <= res_next;
                    carry_q <= chunk_sum[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        sum_q       <= final_sum;
                        c_out_q     <= chunk_sum[CHUNK];
                        ovf_q       <= ovf_now;
                        zero_q      <= (final_sum == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Self-checking bench: three instances (CHUNK=4,1,16) share stimulus and are
// compared against an integer-arithmetic reference model.
module tb_multicycle_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        sel = 1'b0;
    logic [2:0]  in_ready_v, out_valid_v, c_v, o_v, z_v;
    logic [15:0] sum_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_add_sub #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .x(x), .y(y), .sel(sel), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .sum(sum_v[0]), .c_out(c_v[0]), .overflow(o_v[0]), .zero(z_v[0]));

    multicycle_add_sub #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .x(x), .y(y), .sel(sel), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .sum(sum_v[1]), .c_out(c_v[1]), .overflow(o_v[1]), .zero(z_v[1]));

    multicycle_add_sub #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .x(x), .y(y), .sel(sel), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .sum(sum_v[2]), .c_out(c_v[2]), .overflow(o_v[2]), .zero(z_v[2]));

    function automatic int latency_of(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // Reference: signed/unsigned integer arithmetic, no bit-level carry chain.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        int          sa, sb, st;
        int unsigned ua, ub;
        logic [15:0] r;
        logic        c, o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = {16'd0, a};
        ub = {16'd0, b};
        st = s ? (sa - sb) : (sa + sb);
        c  = s ? (ua >= ub) : ((ua + ub) >= 32'd65536);
        o  = (st > 32767) || (st < -32768);
        r  = 16'(st);
`ifdef SATURATE_EN
        if (o) r = (st > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {r, c, o, (r == 16'h0000)};
    endfunction

    // One operation on all three instances; hold = cycles of backpressure in DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int hold);
        logic [18:0] exp_v;
        int          lat [3];
        exp_v = model(a, b, s);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        @(negedge clk);
        x = a; y = b; sel = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); sel = 1'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (in_ready_v !== 3'b000) begin
                bad++;
                $display("FAIL busy_in_ready cycle %0d: got %b want 000", k, in_ready_v);
            end
            for (int i = 0; i < 3; i++)
                if (lat[i] < 0 && out_valid_v[i] === 1'b1) lat[i] = k;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (lat[i] != latency_of(i)) begin
                bad++;
                $display("FAIL latency dut%0d: got %0d want %0d", i, lat[i], latency_of(i));
            end
            total++;
            if ({sum_v[i], c_v[i], o_v[i], z_v[i]} !== exp_v) begin
                bad++;
                $display("FAIL result dut%0d %h %s %h: got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                         i, a, s ? "-" : "+", b, sum_v[i], c_v[i], o_v[i], z_v[i],
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            x = 16'($urandom); y = 16'($urandom); sel = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (out_valid_v !== 3'b111 || in_ready_v !== 3'b000 ||
                {sum_v[0], c_v[0], o_v[0], z_v[0]} !== exp_v ||
                {sum_v[2], c_v[2], o_v[2], z_v[2]} !== exp_v) begin
                bad++;
                $display("FAIL backpressure cycle %0d: got ov=%b ir=%b sum0=%h sum2=%h want ov=111 ir=000 sum=%h",
                         k, out_valid_v, in_ready_v, sum_v[0], sum_v[2], exp_v[18:3]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (in_ready_v !== 3'b111 || out_valid_v !== 3'b000) begin
            bad++;
            $display("FAIL handshake: got ir=%b ov=%b want ir=111 ov=000", in_ready_v, out_valid_v);
        end
        total++;
        if ({sum_v[1], c_v[1], o_v[1], z_v[1]} !== exp_v) begin
            bad++;
            $display("FAIL hold_after_handshake: got sum=%h want sum=%h", sum_v[1], exp_v[18:3]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (out_valid_v !== 3'b000 || c_v !== 3'b000 || o_v !== 3'b000 || z_v !== 3'b000 ||
            sum_v[0] !== 16'h0 || sum_v[1] !== 16'h0 || sum_v[2] !== 16'h0) begin
            bad++;
            $display("FAIL %s: got ov=%b c=%b o=%b z=%b sums=%h/%h/%h want all zero",
                     tag, out_valid_v, c_v, o_v, z_v, sum_v[0], sum_v[1], sum_v[2]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready_v !== 3'b111) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 111", in_ready_v);
        end
    endtask

    task automatic test_directed();
        do_op(16'h1234, 16'h0FFF, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 0);
        do_op(16'h0007, 16'h0007, 1'b1, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        do_op(16'h4321, 16'h1111, 1'b1, 10);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        x = 16'h1234; y = 16'h4321; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_op");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
